ofs_fim_pcie_ss_rx_multi_stream: RTL and testbench

- Parametrised RX packet router for the PCIe SS shim layer. Input is a segmented AXI-S stream: NUM_OF_SEG segments per beat, with multiple headers and empty segments allowed in one beat.
- Every segment is classified into one of NUM_OUT channels: 0 = completions with data, 1 = requests and completions without data, 2 = messages (NUM_OUT=3 only).
- Each channel has its own DEPTH-entry beat FIFO, so output consumers may backpressure independently. They are not required to hold tready high.
- Sits between the PCIe SS RX port and the AFU-side demux.

---
 rtl/ofs_fim_pcie_ss_rx_multi_stream.sv | 181 ++++++++++++++++++
 tb/tb_ofs_fim_pcie_ss_rx_multi_stream.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_fim_pcie_ss_rx_multi_stream.sv
// rtl/ofs_fim_pcie_ss_rx_multi_stream.sv - segmented RX stream router into per-class beat FIFOs
// Segments are classified by TLP type and each channel gets its own independently drained FIFO.
module ofs_fim_pcie_ss_rx_multi_stream #(
   parameter int NUM_OF_SEG      = 2,
   parameter int SEG_TDATA_WIDTH = 256,
   parameter int SB_HEADERS      = 0,
   parameter int NUM_OUT         = 3,
   parameter int DEPTH           = 4,
   parameter int CNT_WIDTH       = 32
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          in_tvalid,
   output logic                                          in_tready,
   input  logic [NUM_OF_SEG*SEG_TDATA_WIDTH-1:0]         in_tdata,
   input  logic [NUM_OF_SEG*SEG_TDATA_WIDTH/8-1:0]       in_tkeep,
   input  logic                                          in_tlast,
   input  logic [NUM_OF_SEG*258-1:0]                     in_tuser,
   output logic [NUM_OUT-1:0]                            out_tvalid,
   input  logic [NUM_OUT-1:0]                            out_tready,
   output logic [NUM_OUT*NUM_OF_SEG*SEG_TDATA_WIDTH-1:0] out_tdata,
   output logic [NUM_OUT*NUM_OF_SEG*SEG_TDATA_WIDTH/8-1:0] out_tkeep,
   output logic [NUM_OUT-1:0]                            out_tlast,
   output logic [NUM_OUT*NUM_OF_SEG*258-1:0]             out_tuser,
   output logic [NUM_OUT*CNT_WIDTH-1:0]                  stat_pkt_cnt
);
   localparam int SW = SEG_TDATA_WIDTH;
   localparam int KS = SW/8;
   localparam int DW = NUM_OF_SEG*SW;
   localparam int KW = DW/8;
   localparam int UW = NUM_OF_SEG*258;
   localparam int AW = $clog2(DEPTH);

   logic [NUM_OF_SEG-1:0]        seg_hvld, seg_last, seg_asg;
   logic [NUM_OF_SEG-1:0][7:0]   seg_ft;
   logic [NUM_OF_SEG-1:0][1:0]   seg_cls;
   logic                         p_asg, p_last;
   logic [1:0]                   p_cls;
   logic                         cont_vld;
   logic [1:0]                   cont_cls;
   logic                         last_closed;
   logic                         hs;

   logic [NUM_OUT-1:0][DW-1:0]   beat_d;
   logic [NUM_OUT-1:0][KW-1:0]   beat_k;
   logic [NUM_OUT-1:0][UW-1:0]   beat_u;
   logic [NUM_OUT-1:0]           beat_l, beat_sel;

   logic [DW-1:0] mem_d [NUM_OUT][DEPTH];
   logic [KW-1:0] mem_k [NUM_OUT][DEPTH];
   logic [UW-1:0] mem_u [NUM_OUT][DEPTH];
   logic          mem_l [NUM_OUT][DEPTH];

   logic [NUM_OUT-1:0][AW:0]          wr_ptr, rd_ptr;
   logic [NUM_OUT-1:0]                fifo_full, fifo_empty, push, pop;
   logic [NUM_OUT-1:0][CNT_WIDTH-1:0] cnt;

   function automatic logic [1:0] hdr_class(input logic [7:0] ft);
      logic cpl, data, msg;
      cpl  = (ft[4:0] == 5'b01010);
      data = ft[6];
      msg  = (ft[4:3] == 2'b10);
      if (cpl && data)
         return 2'd0;
      else if (msg && NUM_OUT == 3)
         return 2'd2;
      else
         return 2'd1;
   endfunction

   always_comb begin
      for (int s = 0; s < NUM_OF_SEG; s++) begin
         seg_hvld[s] = in_tuser[s*258];
         seg_last[s] = in_tuser[s*258+1];
         seg_ft[s]   = (SB_HEADERS != 0) ? in_tuser[s*258+2+24 +: 8] : in_tdata[s*SW+24 +: 8];
      end
   end

   // A headerless segment continues the previous segment's packet unless that packet closed there.
   always_comb begin
      p_asg  = cont_vld;
      p_cls  = cont_cls;
      p_last = 1'b0;
      for (int s = 0; s < NUM_OF_SEG; s++) begin
         if (seg_hvld[s]) begin
            seg_asg[s] = 1'b1;
            seg_cls[s] = hdr_class(seg_ft[s]);
         end else if (p_last) begin
            seg_asg[s] = 1'b0;
            seg_cls[s] = p_cls;
         end else begin
            seg_asg[s] = p_asg;
            seg_cls[s] = p_cls;
         end
         p_asg  = seg_asg[s];
         p_cls  = seg_cls[s];
         p_last = seg_last[s];
      end
   end

   assign last_closed = (NUM_OF_SEG > 1) ? seg_last[NUM_OF_SEG-1] : in_tlast;

   always_comb begin
      for (int c = 0; c < NUM_OUT; c++) begin
         beat_d[c]   = '0;
         beat_k[c]   = '0;
         beat_u[c]   = '0;
         beat_l[c]   = 1'b0;
         beat_sel[c] = 1'b0;
         for (int s = 0; s < NUM_OF_SEG; s++) begin
            if (seg_asg[s] && seg_cls[s] == 2'(c)) begin
               beat_d[c][s*SW +: SW]   = in_tdata[s*SW +: SW];
               beat_k[c][s*KS +: KS]   = in_tkeep[s*KS +: KS];
               beat_u[c][s*258 +: 258] = in_tuser[s*258 +: 258];
               beat_sel[c]             = 1'b1;
               beat_l[c]               = beat_l[c] | ((NUM_OF_SEG > 1) ? seg_last[s] : in_tlast);
            end
         end
      end
   end

   // Ready looks only at registered occupancy, so a full FIFO stalls input even while popping.
   always_comb begin
      for (int c = 0; c < NUM_OUT; c++) begin
         fifo_empty[c] = (wr_ptr[c] == rd_ptr[c]);
         fifo_full[c]  = ((wr_ptr[c] - rd_ptr[c]) == (AW+1)'(DEPTH));
         pop[c]        = !fifo_empty[c] && out_tready[c];
      end
      in_tready = !rst && !(|fifo_full);
      hs        = in_tvalid && in_tready;
      push      = beat_sel & {NUM_OUT{hs}};
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_OUT; c++) begin
         if (push[c]) begin
            mem_d[c][wr_ptr[c][AW-1:0]] <= beat_d[c];
            mem_k[c][wr_ptr[c][AW-1:0]] <= beat_k[c];
            mem_u[c][wr_ptr[c][AW-1:0]] <= beat_u[c];
            mem_l[c][wr_ptr[c][AW-1:0]] <= beat_l[c];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cont_vld <= 1'b0;
         cont_cls <= 2'd0;
         cnt      <= '0;
      end else begin
         for (int c = 0; c < NUM_OUT; c++) begin
            if (push[c])
               wr_ptr[c] <= wr_ptr[c] + 1'b1;
            if (pop[c]) begin
               rd_ptr[c] <= rd_ptr[c] + 1'b1;
               if (mem_l[c][rd_ptr[c][AW-1:0]])
                  cnt[c] <= cnt[c] + 1'b1;
            end
         end
         if (hs) begin
            cont_vld <= seg_asg[NUM_OF_SEG-1] && !last_closed;
            cont_cls <= seg_cls[NUM_OF_SEG-1];
         end
      end
   end

   always_comb begin
      for (int c = 0; c < NUM_OUT; c++) begin
         out_tvalid[c]          = !fifo_empty[c];
         out_tdata[c*DW +: DW]  = fifo_empty[c] ? '0 : mem_d[c][rd_ptr[c][AW-1:0]];
         out_tkeep[c*KW +: KW]  = fifo_empty[c] ? '0 : mem_k[c][rd_ptr[c][AW-1:0]];
         out_tuser[c*UW +: UW]  = fifo_empty[c] ? '0 : mem_u[c][rd_ptr[c][AW-1:0]];
         out_tlast[c]           = fifo_empty[c] ? 1'b0 : mem_l[c][rd_ptr[c][AW-1:0]];
      end
   end

   assign stat_pkt_cnt = cnt;

endmodule

// File: tb/tb_ofs_fim_pcie_ss_rx_multi_stream.sv
// tb/tb_ofs_fim_pcie_ss_rx_multi_stream.sv - bench for the RX multi-stream router
// Queue-based reference model for a 3-channel instance; small 2-channel instance for routing and wrap.
module tb_ofs_fim_pcie_ss_rx_multi_stream;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          a_in_tvalid, a_in_tready, a_in_tlast;
   logic [511:0]  a_in_tdata;
   logic [63:0]   a_in_tkeep;
   logic [515:0]  a_in_tuser;
   logic [2:0]    a_out_tvalid, a_out_tready, a_out_tlast;
   logic [1535:0] a_out_tdata;
   logic [191:0]  a_out_tkeep;
   logic [1547:0] a_out_tuser;
   logic [95:0]   a_stat;

   logic          b_in_tvalid, b_in_tready, b_in_tlast;
   logic [511:0]  b_in_tdata;
   logic [63:0]   b_in_tkeep;
   logic [515:0]  b_in_tuser;
   logic [1:0]    b_out_tvalid, b_out_tready, b_out_tlast;
   logic [1023:0] b_out_tdata;
   logic [127:0]  b_out_tkeep;
   logic [1031:0] b_out_tuser;
   logic [3:0]    b_stat;

   ofs_fim_pcie_ss_rx_multi_stream #(
      .NUM_OF_SEG(2), .SEG_TDATA_WIDTH(256), .SB_HEADERS(0),
      .NUM_OUT(3), .DEPTH(4), .CNT_WIDTH(32)
   ) dut_a (
      .clk(clk), .rst(rst),
      .in_tvalid(a_in_tvalid), .in_tready(a_in_tready), .in_tdata(a_in_tdata),
      .in_tkeep(a_in_tkeep), .in_tlast(a_in_tlast), .in_tuser(a_in_tuser),
      .out_tvalid(a_out_tvalid), .out_tready(a_out_tready), .out_tdata(a_out_tdata),
      .out_tkeep(a_out_tkeep), .out_tlast(a_out_tlast), .out_tuser(a_out_tuser),
      .stat_pkt_cnt(a_stat)
   );

   ofs_fim_pcie_ss_rx_multi_stream #(
      .NUM_OF_SEG(2), .SEG_TDATA_WIDTH(256), .SB_HEADERS(0),
      .NUM_OUT(2), .DEPTH(4), .CNT_WIDTH(2)
   ) dut_b (
      .clk(clk), .rst(rst),
      .in_tvalid(b_in_tvalid), .in_tready(b_in_tready), .in_tdata(b_in_tdata),
      .in_tkeep(b_in_tkeep), .in_tlast(b_in_tlast), .in_tuser(b_in_tuser),
      .out_tvalid(b_out_tvalid), .out_tready(b_out_tready), .out_tdata(b_out_tdata),
      .out_tkeep(b_out_tkeep), .out_tlast(b_out_tlast), .out_tuser(b_out_tuser),
      .stat_pkt_cnt(b_stat)
   );

   typedef struct packed {
      logic [511:0] d;
      logic [63:0]  k;
      logic [515:0] u;
      logic         l;
   } beat_t;

   beat_t       q [3][$];
   logic [31:0] m_cnt [3];
   bit          m_cont_v;
   int          m_cont_c;
   bit          m_hs;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  fts [6] = '{8'h4A, 8'h0A, 8'h60, 8'h00, 8'h30, 8'h34};

   task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic int class_of(input logic [7:0] ft);
      if ((ft & 8'h1F) == 8'h0A && (ft & 8'h40) != 0) return 0;
      if ((ft & 8'h18) == 8'h10) return 2;
      return 1;
   endfunction

   task automatic set_seg(input int s, input logic hv, input logic ls, input logic [7:0] ft);
      logic [255:0] d;
      d = rand256();
      d[31:24] = ft;
      a_in_tdata[s*256 +: 256] = d;
      a_in_tkeep[s*32 +: 32]   = $urandom;
      a_in_tuser[s*258 +: 258] = {rand256(), ls, hv};
   endtask

   // Called right after inputs change at a falling edge; predicts the next rising edge, checks after it.
   task automatic cycle();
      bit    rdy, open_v, hv, ls;
      int    open_c;
      bit    asg [2];
      int    cl [2];
      beat_t e;
      bit    any;
      #1;
      if (rst) begin
         for (int c = 0; c < 3; c++) begin
            q[c].delete();
            m_cnt[c] = 0;
         end
         m_cont_v = 0;
      end
      rdy = !rst;
      for (int c = 0; c < 3; c++) if (q[c].size() >= 4) rdy = 0;
      chk("in_tready", a_in_tready, rdy);
      m_hs = a_in_tvalid && rdy;
      if (!rst) begin
         for (int c = 0; c < 3; c++) begin
            if (q[c].size() != 0 && a_out_tready[c]) begin
               if (q[c][0].l) m_cnt[c]++;
               void'(q[c].pop_front());
            end
         end
         if (m_hs) begin
            open_v = m_cont_v;
            open_c = m_cont_c;
            for (int s = 0; s < 2; s++) begin
               hv = a_in_tuser[s*258];
               ls = a_in_tuser[s*258+1];
               if (hv) begin
                  open_v = 1;
                  open_c = class_of(a_in_tdata[s*256+24 +: 8]);
               end
               asg[s] = open_v;
               cl[s]  = open_c;
               if (ls) open_v = 0;
            end
            m_cont_v = open_v;
            m_cont_c = open_c;
            for (int c = 0; c < 3; c++) begin
               e = '0;
               any = 0;
               for (int s = 0; s < 2; s++) begin
                  if (asg[s] && cl[s] == c) begin
                     any = 1;
                     e.d[s*256 +: 256] = a_in_tdata[s*256 +: 256];
                     e.k[s*32 +: 32]   = a_in_tkeep[s*32 +: 32];
                     e.u[s*258 +: 258] = a_in_tuser[s*258 +: 258];
                     e.l = e.l | a_in_tuser[s*258+1];
                  end
               end
               if (any) q[c].push_back(e);
            end
         end
      end
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         e = (q[c].size() != 0) ? q[c][0] : '0;
         chk($sformatf("tvalid%0d", c), a_out_tvalid[c], q[c].size() != 0);
         chk($sformatf("tdata%0d", c), a_out_tdata[c*512 +: 512], e.d);
         chk($sformatf("tkeep%0d", c), a_out_tkeep[c*64 +: 64], e.k);
         chk($sformatf("tuser%0d", c), a_out_tuser[c*516 +: 516], e.u);
         chk($sformatf("tlast%0d", c), a_out_tlast[c], e.l);
         chk($sformatf("cnt%0d", c), a_stat[c*32 +: 32], m_cnt[c]);
      end
   endtask

   task automatic b_send_msg();
      b_in_tdata = {rand256(), rand256()};
      b_in_tdata[31:24] = 8'h30;
      b_in_tkeep = '1;
      b_in_tuser = '0;
      b_in_tuser[1:0] = 2'b11;
      b_in_tvalid = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int acc;
      rst = 1'b1;
      a_in_tvalid = 0; a_in_tlast = 0; a_in_tdata = '0; a_in_tkeep = '0; a_in_tuser = '0;
      a_out_tready = '0;
      b_in_tvalid = 0; b_in_tlast = 0; b_in_tdata = '0; b_in_tkeep = '0; b_in_tuser = '0;
      b_out_tready = 2'b11;
      for (int c = 0; c < 3; c++) m_cnt[c] = 0;
      m_cont_v = 0;
      m_cont_c = 0;
      @(negedge clk);
      cycle();
      chk("rst_tready", a_in_tready, 1'b0);
      rst = 1'b0;
      cycle();

      // CplD and MWr in one beat, each closing in its own segment
      set_seg(0, 1, 1, 8'h4A);
      set_seg(1, 1, 1, 8'h60);
      a_in_tvalid = 1;
      cycle();
      chk("t1_valid", a_out_tvalid, 3'b011);
      chk("t1_ch0_seg1", a_out_tdata[511:256], 256'd0);
      chk("t1_ch1_seg0", a_out_tdata[767:512], 256'd0);
      a_in_tvalid = 0;
      a_out_tready = 3'b111;
      cycle();
      chk("t1_cnt0", a_stat[31:0], 32'd1);
      chk("t1_cnt1", a_stat[63:32], 32'd1);

      // 3-beat CplD starting in seg1, ending in seg0 of the third beat
      set_seg(0, 0, 0, 8'h00);
      set_seg(1, 1, 0, 8'h4A);
      a_in_tvalid = 1;
      cycle();
      chk("t2_b0_tlast", a_out_tlast[0], 1'b0);
      set_seg(0, 0, 0, 8'h00);
      set_seg(1, 0, 0, 8'h00);
      cycle();
      set_seg(0, 0, 1, 8'h00);
      set_seg(1, 0, 0, 8'h00);
      cycle();
      chk("t2_b2_tlast", a_out_tlast[0], 1'b1);
      chk("t2_ch1_idle", a_out_tvalid[1], 1'b0);
      a_in_tvalid = 0;
      cycle();
      chk("t2_cnt0", a_stat[31:0], 32'd2);

      // Message goes to channel 2
      set_seg(0, 1, 1, 8'h30);
      set_seg(1, 0, 0, 8'h00);
      a_in_tvalid = 1;
      cycle();
      chk("t3_msg", a_out_tvalid, 3'b100);
      a_in_tvalid = 0;
      cycle();

      // Channel 0 stalled while channel 1 drains
      a_out_tready = 3'b110;
      set_seg(0, 1, 1, 8'h4A);
      set_seg(1, 1, 1, 8'h60);
      a_in_tvalid = 1;
      acc = 0;
      for (int i = 0; i < 40 && acc < 5; i++) begin
         if (i == 11) chk("bp_stall", a_in_tready, 1'b0);
         if (i == 12) a_out_tready = 3'b111;
         cycle();
         if (m_hs) begin
            acc++;
            set_seg(0, 1, 1, 8'h4A);
            set_seg(1, 1, 1, 8'h60);
         end
      end
      chk("bp_accepted", acc, 5);
      a_in_tvalid = 0;
      for (int i = 0; i < 6; i++) cycle();

      // Randomized traffic with random per-channel backpressure
      for (int i = 0; i < 300; i++) begin
         a_in_tvalid = ($urandom_range(0, 3) != 0);
         for (int s = 0; s < 2; s++)
            set_seg(s, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), fts[$urandom_range(0, 5)]);
         a_in_tlast = 1'($urandom);
         a_out_tready = 3'($urandom);
         cycle();
      end
      a_in_tvalid = 0;
      a_out_tready = 3'b111;
      for (int i = 0; i < 8; i++) cycle();

      // Reset with an open packet, then a headerless segment
      a_out_tready = 3'b000;
      set_seg(0, 1, 0, 8'h4A);
      set_seg(1, 0, 0, 8'h00);
      a_in_tvalid = 1;
      cycle();
      a_in_tvalid = 0;
      rst = 1'b1;
      cycle();
      chk("rst_valid", a_out_tvalid, 3'b000);
      rst = 1'b0;
      a_out_tready = 3'b111;
      set_seg(0, 0, 0, 8'h00);
      set_seg(1, 0, 0, 8'h00);
      a_in_tvalid = 1;
      cycle();
      chk("post_rst_valid", a_out_tvalid, 3'b000);
      chk("post_rst_cnt", a_stat, 96'd0);
      a_in_tvalid = 0;
      cycle();

      // Two-channel instance: message lands in channel 1; 2-bit counter wraps
      b_send_msg();
      @(negedge clk);
      b_in_tvalid = 0;
      chk("b_msg_valid", b_out_tvalid, 2'b10);
      chk("b_msg_tlast", b_out_tlast, 2'b10);
      @(negedge clk);
      chk("b_cnt1_one", b_stat, 4'b0100);
      for (int i = 0; i < 3; i++) begin
         b_send_msg();
         chk("b_tready", b_in_tready, 1'b1);
         @(negedge clk);
      end
      b_in_tvalid = 0;
      @(negedge clk);
      @(negedge clk);
      chk("b_cnt_wrap", b_stat, 4'b0000);
      chk("b_idle", b_out_tvalid, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
